// File: rtl/mole_pkg.sv
// rtl/mole_pkg.sv - shared types, widths and helpers for the whack-a-mole round logic
package mole_pkg;

  localparam int MOLE_POS_W = 3;
  localparam int NUM_MOLES  = 8;
  localparam int SCORE_W    = 8;
  localparam int MISS_W     = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SPAWN,
    ST_SHOW,
    ST_GAP,
    ST_OVER
  } mole_state_t;

  // Candidate comes from the low LFSR bits; a repeat of the last mole is bumped to the next hole.
  function automatic logic [MOLE_POS_W-1:0] spawn_pos(input logic [7:0] lfsr,
                                                      input logic [MOLE_POS_W-1:0] prev);
    logic [MOLE_POS_W-1:0] cand;
    cand = lfsr[MOLE_POS_W-1:0];
    if (cand == prev) begin
      cand = cand + MOLE_POS_W'(1);
    end
    return cand;
  endfunction

endpackage

// File: rtl/mole_lfsr.sv
// rtl/mole_lfsr.sv - free-running 8-bit Fibonacci LFSR, taps 8,6,5,4
module mole_lfsr #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] lfsr
);

  // Shift left every cycle, feedback from taps 8,6,5,4 into bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= SEED;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

endmodule

// File: rtl/mole_round_ctrl.sv
// rtl/mole_round_ctrl.sv - round sequencer: spawn, show window, judge, gap, score/miss keeping (option: MOLE_SPEEDUP_EN)
import mole_pkg::*;

module mole_round_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned GAP_CYCLES     = 25_000_000,
  parameter int unsigned MAX_MISSES     = 5,
  parameter logic [7:0]  LFSR_SEED      = 8'hA5
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_btn_valid,
  input  logic [MOLE_POS_W-1:0] i_btn_pos,
  output logic [MOLE_POS_W-1:0] o_mole_position,
  output logic                  o_mole_visible,
  output logic [MOLE_POS_W-1:0] o_user_guess,
  output logic                  o_user_right,
  output logic                  o_user_wrong,
  output logic                  o_timeout,
  output logic [SCORE_W-1:0]    o_score,
  output logic [MISS_W-1:0]     o_misses,
  output logic                  o_game_over
);

  localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int          CNT_W   = $clog2(CNT_MAX + 1);

  mole_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] window_load;
  logic [7:0]       lfsr;
  logic             hit;

  mole_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .lfsr  (lfsr)
  );

  assign hit = (state == ST_SHOW) && i_btn_valid && (i_btn_pos == o_mole_position);

`ifdef MOLE_SPEEDUP_EN
  localparam logic [CNT_W-1:0] WIN_FULL  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] WIN_FLOOR = CNT_W'(TIMEOUT_CYCLES / 4);

  logic             start_game;
  logic [CNT_W-1:0] reload;
  logic [CNT_W-1:0] reload_dec;

  assign start_game  = ((state == ST_IDLE) || (state == ST_OVER)) && i_start;
  assign reload_dec  = reload - (reload >> 3);
  assign window_load = reload - CNT_W'(1);

  // Shrink the window by 1/8 on every 8th hit, never below a quarter of the full window.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      reload <= WIN_FULL;
    end else if (start_game) begin
      reload <= WIN_FULL;
    end else if (hit && (o_score != '1) && (o_score[2:0] == 3'd7)) begin
      reload <= (reload_dec < WIN_FLOOR) ? WIN_FLOOR : reload_dec;
    end
  end
`else
  assign window_load = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  // Round FSM with shared window/gap counter; all outputs registered here.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      o_mole_position <= '0;
      o_mole_visible  <= 1'b0;
      o_user_guess    <= '0;
      o_user_right    <= 1'b0;
      o_user_wrong    <= 1'b0;
      o_timeout       <= 1'b0;
      o_score         <= '0;
      o_misses        <= '0;
      o_game_over     <= 1'b0;
    end else begin
      o_user_right <= 1'b0;
      o_user_wrong <= 1'b0;
      o_timeout    <= 1'b0;
      case (state)
        ST_IDLE, ST_OVER: begin
          if (i_start) begin
            o_score     <= '0;
            o_misses    <= '0;
            o_game_over <= 1'b0;
            state       <= ST_SPAWN;
          end
        end
        ST_SPAWN: begin
          o_mole_position <= spawn_pos(lfsr, o_mole_position);
          cnt             <= window_load;
          o_mole_visible  <= 1'b1;
          state           <= ST_SHOW;
        end
        ST_SHOW: begin
          // A press on the expiry cycle is judged; the timeout only fires with no press.
          if (i_btn_valid) begin
            o_user_guess <= i_btn_pos;
            if (hit) begin
              o_user_right <= 1'b1;
              if (o_score != '1) o_score <= o_score + SCORE_W'(1);
            end else begin
              o_user_wrong <= 1'b1;
              if (o_misses != '1) o_misses <= o_misses + MISS_W'(1);
            end
            o_mole_visible <= 1'b0;
            cnt            <= CNT_W'(GAP_CYCLES - 1);
            state          <= ST_GAP;
          end else if (cnt == '0) begin
            o_timeout      <= 1'b1;
            if (o_misses != '1) o_misses <= o_misses + MISS_W'(1);
            o_mole_visible <= 1'b0;
            cnt            <= CNT_W'(GAP_CYCLES - 1);
            state          <= ST_GAP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (cnt == '0) begin
            if (o_misses >= MISS_W'(MAX_MISSES)) begin
              o_game_over <= 1'b1;
              state       <= ST_OVER;
            end else begin
              state <= ST_SPAWN;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mole_round_ctrl.sv
// tb/tb_mole_round_ctrl.sv - scoreboard bench for mole_round_ctrl
module tb_mole_round_ctrl;

  localparam int         T    = 20;
  localparam int         G    = 4;
  localparam int         MM   = 3;
  localparam logic [7:0] SEED = 8'hA5;

  localparam int K_RIGHT   = 0;
  localparam int K_WRONG   = 1;
  localparam int K_TIMEOUT = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_start = 1'b0;
  logic       i_btn_valid = 1'b0;
  logic [2:0] i_btn_pos = '0;
  logic [2:0] o_mole_position;
  logic       o_mole_visible;
  logic [2:0] o_user_guess;
  logic       o_user_right;
  logic       o_user_wrong;
  logic       o_timeout;
  logic [7:0] o_score;
  logic [3:0] o_misses;
  logic       o_game_over;

  mole_round_ctrl #(
    .TIMEOUT_CYCLES(T), .GAP_CYCLES(G), .MAX_MISSES(MM), .LFSR_SEED(SEED)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start),
    .i_btn_valid(i_btn_valid), .i_btn_pos(i_btn_pos),
    .o_mole_position(o_mole_position), .o_mole_visible(o_mole_visible),
    .o_user_guess(o_user_guess), .o_user_right(o_user_right),
    .o_user_wrong(o_user_wrong), .o_timeout(o_timeout),
    .o_score(o_score), .o_misses(o_misses), .o_game_over(o_game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int guess;
    int score;
    int misses;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference LFSR; m_spawn holds the value seen during the previous cycle.
  logic [7:0] m_lfsr, m_spawn;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr  <= SEED;
      m_spawn <= SEED;
    end else begin
      m_spawn <= m_lfsr;
      m_lfsr  <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
  end

  // Monitor: pops expectations on every pulse and checks spawn position and phase lengths.
  logic [2:0] exp_prev_pos, cand;
  logic       vis_d, over_d;
  int         show_cyc, since_pulse, act_kind;
  bit         had_pulse;
  exp_t       e;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_prev_pos = '0;
      vis_d        = 1'b0;
      over_d       = 1'b0;
      show_cyc     = 0;
      since_pulse  = 0;
      had_pulse    = 0;
    end else begin
      if (had_pulse) since_pulse++;
      if (o_mole_visible && !vis_d) begin
        show_cyc = 1;
        cand = m_spawn[2:0];
        if (cand == exp_prev_pos) cand = cand + 3'd1;
        check("spawn_pos", 32'(o_mole_position), 32'(cand));
        check("pos_changed", 32'(o_mole_position != exp_prev_pos), 32'd1);
        exp_prev_pos = cand;
        if (had_pulse) check("gap_plus_spawn_len", since_pulse, G + 1);
      end else if (o_mole_visible) begin
        show_cyc++;
      end
      if (o_user_right || o_user_wrong || o_timeout) begin
        check("pulse_exclusive", 32'(o_user_right) + 32'(o_user_wrong) + 32'(o_timeout), 32'd1);
        act_kind = o_user_right ? K_RIGHT : (o_user_wrong ? K_WRONG : K_TIMEOUT);
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_pulse: got kind %0d, expected no pulse", act_kind);
        end else begin
          e = sbq.pop_front();
          check("pulse_kind", act_kind, e.kind);
          check("guess", 32'(o_user_guess), e.guess);
          check("score", 32'(o_score), e.score);
          check("misses", 32'(o_misses), e.misses);
          if (o_timeout) check("timeout_window", show_cyc, T);
        end
        since_pulse = 0;
        had_pulse   = 1;
      end
      if (o_game_over && !over_d) begin
        check("game_over_delay", since_pulse, G);
        had_pulse = 0;
      end
      vis_d  = o_mole_visible;
      over_d = o_game_over;
    end
  end

  int         exp_score, exp_misses;
  logic [2:0] last_guess;

  task automatic wait_visible(output bit ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (o_mole_visible) begin
        ok = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL wait_visible: got visible=0, expected 1 within 200 cycles");
    end
  endtask

  task automatic press(input logic [2:0] pos, input int delay_cycles);
    repeat (delay_cycles) @(posedge clk);
    #1;
    i_btn_valid = 1'b1;
    i_btn_pos   = pos;
    @(posedge clk);
    #1;
    i_btn_valid = 1'b0;
  endtask

  task automatic start_game();
    @(posedge clk);
    #1;
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    check("start_score_clear", 32'(o_score), 32'd0);
    check("start_misses_clear", 32'(o_misses), 32'd0);
    check("start_over_clear", 32'(o_game_over), 32'd0);
    check("spawn_not_visible", 32'(o_mole_visible), 32'd0);
    @(posedge clk);
    #1;
    check("show_after_spawn", 32'(o_mole_visible), 32'd1);
    exp_score  = 0;
    exp_misses = 0;
  endtask

  // mode: 0 hit, 1 wrong button, 2 no press, 3 hit on the expiry cycle
  task automatic do_round(input int mode);
    bit         ok;
    logic [2:0] pos, p;
    wait_visible(ok);
    if (!ok) return;
    pos = o_mole_position;
    case (mode)
      0, 3: begin
        exp_score++;
        last_guess = pos;
        sbq.push_back('{K_RIGHT, int'(pos), exp_score, exp_misses});
        press(pos, (mode == 3) ? T - 1 : 0);
      end
      1: begin
        p = pos + 3'd1;
        exp_misses++;
        last_guess = p;
        sbq.push_back('{K_WRONG, int'(p), exp_score, exp_misses});
        press(p, 0);
      end
      default: begin
        exp_misses++;
        sbq.push_back('{K_TIMEOUT, int'(last_guess), exp_score, exp_misses});
        for (int i = 0; i < T + 5 && o_mole_visible; i++) begin
          @(posedge clk);
          #1;
        end
        check("show_ended", 32'(o_mole_visible), 32'd0);
      end
    endcase
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_position"}, 32'(o_mole_position), 32'd0);
    check({tag, "_visible"}, 32'(o_mole_visible), 32'd0);
    check({tag, "_guess"}, 32'(o_user_guess), 32'd0);
    check({tag, "_right"}, 32'(o_user_right), 32'd0);
    check({tag, "_wrong"}, 32'(o_user_wrong), 32'd0);
    check({tag, "_timeout"}, 32'(o_timeout), 32'd0);
    check({tag, "_score"}, 32'(o_score), 32'd0);
    check({tag, "_misses"}, 32'(o_misses), 32'd0);
    check({tag, "_game_over"}, 32'(o_game_over), 32'd0);
  endtask

  initial begin
    bit ok;
    exp_score  = 0;
    exp_misses = 0;
    last_guess = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_waits", 32'(o_mole_visible), 32'd0);

    start_game();
    do_round(0);
    do_round(1);
    do_round(2);
    do_round(3);
    do_round(1);

    ok = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (o_game_over) begin
        ok = 1;
        break;
      end
    end
    check("game_over", 32'(o_game_over), 32'd1);
    check("over_not_visible", 32'(o_mole_visible), 32'd0);

    press(3'd0, 0);
    press(3'd5, 2);
    repeat (3) @(posedge clk);
    #1;
    check("over_score_hold", 32'(o_score), 32'd2);
    check("over_misses_hold", 32'(o_misses), 32'(MM));
    check("over_guess_hold", 32'(o_user_guess), 32'(last_guess));
    check("over_stays", 32'(o_game_over), 32'd1);

    start_game();
    do_round(0);

    wait_visible(ok);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    check("queue_empty_at_reset", sbq.size(), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("idle_after_reset", 32'(o_mole_visible), 32'd0);
    last_guess = '0;

    start_game();
    do_round(0);
    do_round(1);
    repeat (8) @(posedge clk);
    #1;
    check("queue_drained", sbq.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mole_round_ctrl.md
# mole_round_ctrl

Round sequencer for the whack-a-mole game. Picks a pseudo-random mole position, holds it visible for a bounded window, judges the player's button press against it, and drives the judged result (`guess`, `position`, `right`/`wrong` pulses) into the LED display block. Also keeps the score and miss count and ends the game after a configured number of misses.

## Interface
- `TIMEOUT_CYCLES`, default 50_000_000: cycles a mole stays visible before it counts as a miss.
- `GAP_CYCLES`, default 25_000_000: blank cycles between rounds.
- `MAX_MISSES`, default 5: misses that end the game (1..15).
- `LFSR_SEED`, default 8'hA5: LFSR reset value; must be nonzero.
- `i_clk`  in  1  system clock.
- `i_rst_n`  in  1  asynchronous active-low reset.
- `i_start`  in  1  level/pulse; begins a game from IDLE or OVER.
- `i_btn_valid`  in  1  one-cycle pulse, debounced button press.
- `i_btn_pos`  in  3  index of the pressed button, valid with `i_btn_valid`.
- `o_mole_position`  out  3  current mole index.
- `o_mole_visible`  out  1  high in SHOW.
- `o_user_guess`  out  3  last judged button index.
- `o_user_right`  out  1  one-cycle pulse, correct hit.
- `o_user_wrong`  out  1  one-cycle pulse, wrong button.
- `o_timeout`  out  1  one-cycle pulse, window expired unanswered.
- `o_score`  out  8  hits, saturating.
- `o_misses`  out  4  wrong presses plus timeouts.
- `o_game_over`  out  1  high in OVER.

## Operation
- States: IDLE, SPAWN, SHOW, GAP, OVER.
- IDLE: `i_start`=1 -> clear score/misses -> SPAWN.
- SPAWN (exactly 1 cycle): candidate = `lfsr[2:0]`; if it equals the previous position, use candidate+1 mod 8 (7 -> 0). Register it into `o_mole_position`, load the window counter -> SHOW.
- SHOW:
  - `i_btn_valid` with `i_btn_pos`==position: pulse right, score+1 -> GAP.
  - `i_btn_valid` with any other position: pulse wrong, misses+1 -> GAP.
  - Counter expiry with no press: pulse `o_timeout`, misses+1 -> GAP.
- GAP: count `GAP_CYCLES`. Then go to OVER if misses >= `MAX_MISSES`, else SPAWN.
- OVER: outputs hold their values. `i_start` -> clear counters -> SPAWN.
- `o_user_guess` loads `i_btn_pos` only on a judged press (SHOW). It is unchanged on timeout.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. It advances every cycle in every state.
- Score saturates at 255. Misses saturate at 15.
- `i_btn_valid` is ignored in IDLE, SPAWN, GAP and OVER.
- `i_start` is ignored in SPAWN, SHOW and GAP.

## Timing
- Reset values: state IDLE, lfsr `LFSR_SEED`, all outputs 0 (`o_mole_position` 0, previous position 0).
- Judge latency: `i_btn_valid` sampled at edge N in SHOW -> pulse, counter update and `o_user_guess` all visible after edge N; GAP entered at the same edge.
- Pulses are exactly one cycle wide. right, wrong and timeout are mutually exclusive.
- Press in the same cycle as window expiry: the press wins, and no timeout pulse is issued.
- SHOW lasts exactly `TIMEOUT_CYCLES` cycles if unanswered.
- GAP lasts exactly `GAP_CYCLES` cycles.
- `o_game_over` rises on the cycle after the final GAP count.
- Reset asserted mid-round aborts immediately to the reset values, with no pulses.

## Configuration
- `MOLE_SPEEDUP_EN` defined: the window reload value drops by reload>>3 after every 8th hit, floored at `TIMEOUT_CYCLES`/4. The reload returns to `TIMEOUT_CYCLES` on game start.
- `MOLE_SPEEDUP_EN` undefined: the window is always `TIMEOUT_CYCLES`, and no reload register exists.

## Structure
- Shared package `mole_pkg`:
  - state enum;
  - `MOLE_POS_W`=3;
  - `NUM_MOLES`=8;
  - `SCORE_W`=8;
  - `MISS_W`=4.
- The LED display block also uses the `mole_pkg` position width.
- Sub-module `mole_lfsr` (8-bit, seed parameter, free-running, outputs `lfsr[7:0]`).
- FSM, counters and judging live in the top module.

## Test plan
Bench settings: `TIMEOUT_CYCLES`=20, `GAP_CYCLES`=4, `MAX_MISSES`=3, `LFSR_SEED`=8'hA5.
- Reset then `i_start` pulse -> SPAWN one cycle, SHOW with `o_mole_visible`=1; position matches the model LFSR[2:0] with the repeat rule.
- In SHOW press `i_btn_pos`=position -> `o_user_right` one cycle, `o_score`=1, `o_user_guess`=position, GAP 4 cycles, new position ≠ old.
- Press position+1 mod 8 -> `o_user_wrong` one cycle, `o_misses`=1, score unchanged.
- No press -> `o_timeout` exactly 20 cycles after SHOW entry, `o_misses` increments, `o_user_guess` unchanged.
- Press on the expiry cycle -> only right or wrong pulses.
- Three misses -> `o_game_over`=1, later presses ignored. `i_start` -> counters 0, new round.
- Assert `i_rst_n`=0 mid-SHOW -> all outputs 0 asynchronously, state IDLE.
- With `MOLE_SPEEDUP_EN`: 8 hits -> next window 18 cycles, floor at 5.
